// File: rtl/alu_ex.sv
// -----------------------------------------------------------------------------
// alu_ex_defs : shared widths and encodings used by the execute stage.
// alu_ex      : single-cycle integer ALU / branch resolver of the OoO core.
//
// alu_ex ports
//   clk                     in   clock, all state on posedge
//   rst                     in   synchronous active-low reset
//   rdy                     in   global ready; 0 freezes every output
//   opnum_from_rs           in   issued operation (OPNUM_NULL = nothing)
//   V1_from_rs, V2_from_rs  in   resolved source operands
//   pc_from_rs              in   instruction pc
//   imm_from_rs             in   sign-extended immediate
//   rob_id_from_rs          in   destination ROB tag (INVALID_ROB = nothing)
//   rollback_sign_from_rob  in   misprediction flush
//   valid_sign              out  result broadcast valid
//   rob_id_out              out  tag of the broadcast result
//   data_out                out  value for rd
//   jump_sign               out  control transfer taken
//   target_pc               out  resolved next pc
//
// Broadcast protocol: valid_sign is a one-cycle-per-result strobe with no
// back-pressure. Each accepted issue is broadcast exactly once, in the cycle
// after its accepting edge. Consumers must sample rob_id_out/data_out/
// jump_sign/target_pc whenever valid_sign==1; while rdy==0 the previous
// broadcast is merely held, and consumers freeze with the same rdy.
// -----------------------------------------------------------------------------
package alu_ex_defs;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int OPNUM_W = 6;
  localparam int ROB_W   = 5;

  typedef logic [OPNUM_W-1:0] opnum_t;
  typedef logic [ROB_W-1:0]   rob_id_t;

  localparam rob_id_t INVALID_ROB = 5'd16;

  localparam opnum_t OPNUM_NULL = 6'd0;
  localparam opnum_t OP_LUI     = 6'd1;
  localparam opnum_t OP_AUIPC   = 6'd2;
  localparam opnum_t OP_JAL     = 6'd3;
  localparam opnum_t OP_JALR    = 6'd4;
  localparam opnum_t OP_BEQ     = 6'd5;
  localparam opnum_t OP_BNE     = 6'd6;
  localparam opnum_t OP_BLT     = 6'd7;
  localparam opnum_t OP_BGE     = 6'd8;
  localparam opnum_t OP_BLTU    = 6'd9;
  localparam opnum_t OP_BGEU    = 6'd10;
  localparam opnum_t OP_LB      = 6'd11;
  localparam opnum_t OP_LH      = 6'd12;
  localparam opnum_t OP_LW      = 6'd13;
  localparam opnum_t OP_LBU     = 6'd14;
  localparam opnum_t OP_LHU     = 6'd15;
  localparam opnum_t OP_SB      = 6'd16;
  localparam opnum_t OP_SH      = 6'd17;
  localparam opnum_t OP_SW      = 6'd18;
  localparam opnum_t OP_ADDI    = 6'd19;
  localparam opnum_t OP_SLTI    = 6'd20;
  localparam opnum_t OP_SLTIU   = 6'd21;
  localparam opnum_t OP_XORI    = 6'd22;
  localparam opnum_t OP_ORI     = 6'd23;
  localparam opnum_t OP_ANDI    = 6'd24;
  localparam opnum_t OP_SLLI    = 6'd25;
  localparam opnum_t OP_SRLI    = 6'd26;
  localparam opnum_t OP_SRAI    = 6'd27;
  localparam opnum_t OP_ADD     = 6'd28;
  localparam opnum_t OP_SUB     = 6'd29;
  localparam opnum_t OP_SLL     = 6'd30;
  localparam opnum_t OP_SLT     = 6'd31;
  localparam opnum_t OP_SLTU    = 6'd32;
  localparam opnum_t OP_XOR     = 6'd33;
  localparam opnum_t OP_OR      = 6'd34;
  localparam opnum_t OP_AND     = 6'd35;
  localparam opnum_t OP_SRL     = 6'd36;
  localparam opnum_t OP_SRA     = 6'd37;
endpackage

module alu_ex
  import alu_ex_defs::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  opnum_t            opnum_from_rs,
  input  logic [DATA_W-1:0] V1_from_rs,
  input  logic [DATA_W-1:0] V2_from_rs,
  input  logic [ADDR_W-1:0] pc_from_rs,
  input  logic [DATA_W-1:0] imm_from_rs,
  input  rob_id_t           rob_id_from_rs,
  input  logic              rollback_sign_from_rob,
  output logic              valid_sign,
  output rob_id_t           rob_id_out,
  output logic [DATA_W-1:0] data_out,
  output logic              jump_sign,
  output logic [ADDR_W-1:0] target_pc
);

  logic              op_known;
  logic              take;
  logic [DATA_W-1:0] op2;
  logic [4:0]        shamt;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] pc_rel;
  logic [DATA_W-1:0] res_data;
  logic              res_jump;
  logic [ADDR_W-1:0] res_target;
  logic              accept;

  // I-type arithmetic takes the immediate as its second operand.
  assign op2     = (opnum_from_rs inside {OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI,
                                          OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI})
                   ? imm_from_rs : V2_from_rs;
  assign shamt   = op2[4:0];
  assign pc_next = pc_from_rs + 32'd4;
  assign pc_rel  = pc_from_rs + imm_from_rs;

  always_comb begin
    take = 1'b0;
    unique case (opnum_from_rs)
      OP_BEQ:  take = (V1_from_rs == V2_from_rs);
      OP_BNE:  take = (V1_from_rs != V2_from_rs);
      OP_BLT:  take = ($signed(V1_from_rs) <  $signed(V2_from_rs));
      OP_BGE:  take = ($signed(V1_from_rs) >= $signed(V2_from_rs));
      OP_BLTU: take = (V1_from_rs <  V2_from_rs);
      OP_BGEU: take = (V1_from_rs >= V2_from_rs);
      default: take = 1'b0;
    endcase
  end

  always_comb begin
    op_known   = 1'b1;
    res_data   = '0;
    res_jump   = 1'b0;
    res_target = pc_next;
    case (opnum_from_rs)
      OP_LUI:   res_data = imm_from_rs;
      OP_AUIPC: res_data = pc_rel;
      OP_JAL: begin
        res_data   = pc_next;
        res_jump   = 1'b1;
        res_target = pc_rel;
      end
      OP_JALR: begin
        res_data   = pc_next;
        res_jump   = 1'b1;
        res_target = (V1_from_rs + imm_from_rs) & ~32'd1;
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        res_jump   = take;
        res_target = take ? pc_rel : pc_next;
      end
      OP_ADDI, OP_ADD:   res_data = V1_from_rs + op2;
      OP_SUB:            res_data = V1_from_rs - op2;
      OP_SLTI, OP_SLT:   res_data = {31'd0, $signed(V1_from_rs) < $signed(op2)};
      OP_SLTIU, OP_SLTU: res_data = {31'd0, V1_from_rs < op2};
      OP_XORI, OP_XOR:   res_data = V1_from_rs ^ op2;
      OP_ORI, OP_OR:     res_data = V1_from_rs | op2;
      OP_ANDI, OP_AND:   res_data = V1_from_rs & op2;
      OP_SLLI, OP_SLL:   res_data = V1_from_rs << shamt;
      OP_SRLI, OP_SRL:   res_data = V1_from_rs >> shamt;
      OP_SRAI, OP_SRA:   res_data = DATA_W'($signed(V1_from_rs) >>> shamt);
      // Loads, stores and unknown encodings belong to other units.
      default:           op_known = 1'b0;
    endcase
  end

  assign accept = op_known && (rob_id_from_rs != INVALID_ROB);

  // Priority: reset > rollback > rdy hold > issue / idle.
  always_ff @(posedge clk) begin
    if (!rst || rollback_sign_from_rob) begin
      valid_sign <= 1'b0;
      rob_id_out <= INVALID_ROB;
      data_out   <= '0;
      jump_sign  <= 1'b0;
      target_pc  <= '0;
    end else if (rdy) begin
      if (accept) begin
        valid_sign <= 1'b1;
        rob_id_out <= rob_id_from_rs;
        data_out   <= res_data;
        jump_sign  <= res_jump;
        target_pc  <= res_target;
      end else begin
        // Idle cycle: drop the strobe but keep data_out/target_pc as they were.
        valid_sign <= 1'b0;
        rob_id_out <= INVALID_ROB;
        jump_sign  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/alu_ex.md
ALU_EX -- requirements
Module: alu_ex

Interface
REQ-001 Parameters: none; widths come from the shared defines header. DATA = 32 bits, ADDR = 32 bits, OPNUM per OPNUM_TYPE, ROB id per ROB_ID_TYPE. OPNUM_NULL and INVALID_ROB mean "no instruction".
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-low: state cleared on posedge clk while rst==0.
REQ-004 rdy  input  1  global ready; when 0 the block holds all state and outputs.
REQ-005 opnum_from_rs  input  OPNUM  operation issued by the reservation station this cycle.
REQ-006 V1_from_rs, V2_from_rs  input  32 each  resolved source operands.
REQ-007 pc_from_rs  input  32  instruction pc.
REQ-008 imm_from_rs  input  32  sign-extended immediate.
REQ-009 rob_id_from_rs  input  ROB_ID  destination ROB entry; INVALID_ROB = no issue.
REQ-010 rollback_sign_from_rob  input  1  misprediction flush.
REQ-011 valid_sign  output  1  result broadcast valid (to RS, LSB, ROB).
REQ-012 rob_id_out  output  ROB_ID  tag of the broadcast result.
REQ-013 data_out  output  32  value to write to rd.
REQ-014 jump_sign  output  1  control transfer taken.
REQ-015 target_pc  output  32  resolved next pc for jumps and branches.

Function
REQ-016 An issue is accepted when rdy==1, rob_id_from_rs!=INVALID_ROB and opnum_from_rs!=OPNUM_NULL.
REQ-017 Latency is exactly 1 cycle: an issue accepted at edge N appears on the outputs after edge N and stays stable until edge N+1.
REQ-018 All outputs are registered; there is no combinational path from any input to any output.
REQ-019 No issue (while rdy==1) clears the outputs at the next edge: valid_sign=0, rob_id_out=INVALID_ROB, jump_sign=0. data_out and target_pc hold their previous values.
REQ-020 Operation semantics:
- LUI: data = imm.
- AUIPC: data = pc + imm.
- JAL: data = pc + 4; jump = 1; target = pc + imm.
- JALR: data = pc + 4; jump = 1; target = (V1 + imm) & ~1.
REQ-021 Branches:
- BEQ, BNE, BLT, BGE: compare signed. BLTU, BGEU: compare unsigned.
- data = 0; jump = condition result.
- target = taken ? pc + imm : pc + 4.
REQ-022 I-type ops ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI use imm as the second operand. R-type ops ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA use V2.
REQ-023 Shift amount = operand2[4:0]. SRA/SRAI are arithmetic shifts. SLT/SLTI/SLTU/SLTIU produce 32'd1 or 32'd0.
REQ-024 All arithmetic is modulo 2^32 and wraps silently; there is no overflow flag.
REQ-025 For non-jump, non-branch ops: jump_sign=0 and target_pc = pc + 4.
REQ-026 An opnum not listed in REQ-020..REQ-022 (loads, stores, unknown) is not accepted and is treated as no issue per REQ-019.
REQ-027 rdy==0: the issue presented that cycle is ignored and all outputs hold.
REQ-028 rollback_sign_from_rob==1 with rst==1: the next edge clears the outputs as for reset (REQ-031), the issue presented that cycle is discarded, and rdy is not consulted.
REQ-029 Rollback takes priority over an accepted issue and over rdy==0. Reset takes priority over rollback.
REQ-030 Back-to-back issues on consecutive cycles are each broadcast exactly once, in order; there are no bubbles and no stalls.

Reset
REQ-031 While rst==0 at posedge clk: valid_sign=0, rob_id_out=INVALID_ROB, data_out=0, jump_sign=0, target_pc=0.
REQ-032 Reset takes effect regardless of rdy. The first issue can be accepted on the first edge with rst==1.

Verification
REQ-033 ADD, V1=32'h7FFFFFFF, V2=1, rob_id=3 -> next cycle: valid=1, rob_id_out=3, data=32'h80000000, jump=0.
REQ-034 BLT, V1=32'hFFFFFFFF, V2=0, pc=32'h100, imm=32'h20 -> jump=1, target=32'h120. Same stimulus with BLTU -> jump=0, target=32'h104.
REQ-035 JALR, V1=32'h1003, imm=4, pc=32'h40 -> data=32'h44, jump=1, target=32'h1006.
REQ-036 SRAI, V1=32'h80000000, imm=32'h21 -> data=32'hC0000000 (shift amount 1).
REQ-037 Issue rob_id=5 in the same cycle as rollback=1 -> next cycle valid=0, rob_id_out=INVALID_ROB. Issue rob_id=6 with rdy=0 -> outputs unchanged.
REQ-038 Issue rob_id 1, 2, 3 on consecutive cycles, then rst=0 mid-stream -> broadcasts of 1 and 2 appear in order, then every output reaches its REQ-031 value at the edge that samples rst=0.
